branch_resolve_bpu: RTL and testbench
=====================================

Name: branch_resolve_bpu

Overview:
- Next-generation EX-stage branch unit. Resolves LoongArch branches (one-hot br_type) against the IF-stage prediction and raises a registered flush/redirect on mispredict.
- Owns a parametrised direct-mapped BTB with 2-bit saturating counters. The table is looked up by IF and trained by EX.
- Carries saturating branch and mispredict performance counters.
- Sits between the EX stage and the PC-generation logic.

Parameters:
- ENTRIES, 64, number of BTB entries; power of two, at least 2.
- TAG_W, 10, BTB tag width taken from the PC bits above the index.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_pc  in  32  fetch PC to look up.
- if_pred_taken  out  1  predicted taken for if_pc (combinational).
- if_pred_target  out  32  predicted next PC (combinational).
- ex_valid  in  1  EX holds a valid instruction.
- ex_stall  in  1  EX held this cycle; nothing resolves or trains.
- ex_br_type  in  10  one-hot branch type: bit0 none, bit1 JIRL, bit2 B, bit3 BL, bit4 BEQ, bit5 BNE, bit6 BLT, bit7 BGE, bit8 BLTU, bit9 BGEU. All-zero is treated as none.
- ex_pc  in  32  PC of the EX instruction.
- ex_imm  in  32  sign-extended byte offset.
- ex_rdata1  in  32  rj operand.
- ex_rdata2  in  32  rd operand.
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction.
- ex_pred_target  in  32  predicted next PC carried with this instruction.
- flush  out  1  registered one-cycle mispredict pulse.
- redirect_pc  out  32  correct next PC; meaningful only while flush=1.
- br_cnt  out  CNT_W  resolved branches (bits1..9).
- mispred_cnt  out  CNT_W  resolved mispredicts.

Behaviour:
- Field layout: IW = log2(ENTRIES); index = pc[IW+1:2]; tag = pc[IW+TAG_W+1:IW+2].
- Entry contents: valid, tag, target[31:0], ctr[1:0].
- Lookup (combinational from registered arrays): hit = valid && tag match; if_pred_taken = hit && ctr[1]; if_pred_target = if_pred_taken ? target : if_pc+4.
- No write-to-read bypass: a lookup in the same cycle as an update to that index sees the pre-update contents.
- Resolve (combinational; signed/unsigned compares are full 32-bit; adds are modulo 2^32):
  - taken = B | BL | JIRL | (BEQ & rdata1==rdata2) | (BNE & !=) | (BLT & signed <) | (BGE & signed >=) | (BLTU & unsigned <) | (BGEU & unsigned >=).
  - actual_next = JIRL ? rdata1+imm : (taken ? pc+imm : pc+4).
  - mispred = (taken != ex_pred_taken) || (taken && ex_pred_target != actual_next).
  - A non-branch predicted taken is a mispredict; its redirect is pc+4.
- A resolve event occurs at a rising edge when ex_valid && !ex_stall && !flush (self-squash).
- On each resolve event:
  - flush <= mispred; redirect_pc <= actual_next.
  - Conditional branch, entry hit: ctr saturating +1 if taken, -1 if not taken; target <= actual_next if taken.
  - Conditional branch, miss, taken: allocate with valid=1, tag, target, ctr=2'b10.
  - Conditional branch, miss, not taken: no write.
  - B/BL/JIRL: write valid=1, tag, target, ctr=2'b11.
  - Non-branch that hits: valid <= 0 (aliasing cleanup).
  - br_cnt +1 for any branch; mispred_cnt +1 if mispred. Both saturate at all-ones.
- With no resolve event: flush <= 0; redirect_pc holds its value; no table write.
- Timing:
  - flush is exactly 1 cycle wide and appears the edge after resolve (latency 1).
  - The instruction in EX during the flush cycle is wrong-path: no training, no counting, no flush.
- Reset, synchronous, wins over every other event including a mid-cycle resolve. It sets flush=0, redirect_pc=0, both counters=0, all valid=0, all ctr=2'b01. Tag and target storage need no reset.
- A multi-hot ex_br_type is illegal input; the output is unspecified.

Test Plan:
- Reset, then if_pc=0x1C000000 -> if_pred_taken=0, if_pred_target=0x1C000004; flush=0, counters=0.
- BEQ pc=0x100, imm=0x40, r1=r2=5, pred_taken=0 -> next cycle flush=1, redirect_pc=0x140, mispred_cnt=1. Following cycle flush=0, and lookup of 0x100 gives taken, target 0x140.
- Same BEQ again, pred_taken=1, target=0x140 -> no flush; ctr reaches 2'b11. Then r1=1, r2=2 with pred taken -> flush, redirect_pc=0x104, ctr=2'b10, prediction still taken.
- BLT r1=0xFFFFFFFF, r2=1 -> taken; BLTU with the same operands -> not taken. Both with pred_taken=0: BLT flushes, BLTU does not.
- JIRL r1=0x2000, imm=8, predicted taken with target 0x3000 -> flush, redirect_pc=0x2008, entry target updated to 0x2008. Next instruction valid during the flush cycle -> ignored, no counter change.
- ex_stall=1 with a mispredicting BNE -> no flush, no counter change. Assert rst the same cycle the stall drops -> all outputs 0 and the BTB is empty afterwards.

Source files
------------

// File: rtl/branch_resolve_bpu_if.sv
// EX/IF-side bundle for the branch resolve unit: BTB lookup, EX resolve inputs,
// flush/redirect and performance counters.
interface branch_resolve_bpu_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      if_pc;
    logic             if_pred_taken;
    logic [31:0]      if_pred_target;

    logic             ex_valid;
    logic             ex_stall;
    logic [9:0]       ex_br_type;
    logic [31:0]      ex_pc;
    logic [31:0]      ex_imm;
    logic [31:0]      ex_rdata1;
    logic [31:0]      ex_rdata2;
    logic             ex_pred_taken;
    logic [31:0]      ex_pred_target;

    logic             flush;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output if_pc, ex_valid, ex_stall, ex_br_type, ex_pc, ex_imm,
               ex_rdata1, ex_rdata2, ex_pred_taken, ex_pred_target,
        input  if_pred_taken, if_pred_target, flush, redirect_pc,
               br_cnt, mispred_cnt
    );

    modport slave (
        input  if_pc, ex_valid, ex_stall, ex_br_type, ex_pc, ex_imm,
               ex_rdata1, ex_rdata2, ex_pred_taken, ex_pred_target,
        output if_pred_taken, if_pred_target, flush, redirect_pc,
               br_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_resolve_bpu.sv
// EX-stage LoongArch branch resolver with a direct-mapped 2-bit-counter BTB,
// registered mispredict flush/redirect and saturating perf counters.
module branch_resolve_bpu #(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 10,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    branch_resolve_bpu_if.slave bus
);
    localparam int IW = $clog2(ENTRIES);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic             flush_q;
    logic [31:0]      redirect_q;
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;

    // IF lookup reads only registered state, so a same-cycle update is not visible.
    logic [IW-1:0]    lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_taken;

    assign lk_idx   = bus.if_pc[IW+1:2];
    assign lk_tag   = bus.if_pc[IW+TAG_W+1:IW+2];
    assign lk_taken = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && ctr_q[lk_idx][1];

    assign bus.if_pred_taken  = lk_taken;
    assign bus.if_pred_target = lk_taken ? target_q[lk_idx] : bus.if_pc + 32'd4;

    logic [9:0]       bt;
    logic             is_cond, is_uncond, is_branch;
    logic             eq, lt_s, lt_u, taken, mispred, resolve;
    logic [31:0]      actual_next;
    logic [IW-1:0]    ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;

    assign bt        = bus.ex_br_type;
    assign is_cond   = |bt[9:4];
    assign is_uncond = |bt[3:1];
    assign is_branch = (is_cond | is_uncond) & ~bt[0];
    assign eq        = bus.ex_rdata1 == bus.ex_rdata2;
    assign lt_s      = $signed(bus.ex_rdata1) < $signed(bus.ex_rdata2);
    assign lt_u      = bus.ex_rdata1 < bus.ex_rdata2;

    assign taken = bt[1] | bt[2] | bt[3]
                 | (bt[4] & eq)   | (bt[5] & ~eq)
                 | (bt[6] & lt_s) | (bt[7] & ~lt_s)
                 | (bt[8] & lt_u) | (bt[9] & ~lt_u);

    assign actual_next = bt[1] ? bus.ex_rdata1 + bus.ex_imm
                       : (taken ? bus.ex_pc + bus.ex_imm : bus.ex_pc + 32'd4);

    assign mispred = (taken != bus.ex_pred_taken)
                   || (taken && (bus.ex_pred_target != actual_next));

    // The instruction sitting in EX during a flush cycle is wrong-path and squashed.
    assign resolve = bus.ex_valid && !bus.ex_stall && !flush_q;

    assign ex_idx = bus.ex_pc[IW+1:2];
    assign ex_tag = bus.ex_pc[IW+TAG_W+1:IW+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    logic       ent_we, data_we;
    logic       ent_valid_d;
    logic [1:0] ent_ctr_d;

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        ent_we      = 1'b0;
        data_we     = 1'b0;
        ent_valid_d = valid_q[ex_idx];
        ent_ctr_d   = ctr_q[ex_idx];
        if (resolve) begin
            if (is_uncond) begin
                ent_we      = 1'b1;
                data_we     = 1'b1;
                ent_valid_d = 1'b1;
                ent_ctr_d   = 2'b11;
            end else if (is_cond && ex_hit) begin
                ent_we      = 1'b1;
                data_we     = taken;
                ent_valid_d = 1'b1;
                if (taken)
                    ent_ctr_d = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
                else
                    ent_ctr_d = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
            end else if (is_cond && taken) begin
                ent_we      = 1'b1;
                data_we     = 1'b1;
                ent_valid_d = 1'b1;
                ent_ctr_d   = 2'b10;
            end else if (!is_branch && ex_hit) begin
                ent_we      = 1'b1;
                ent_valid_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q       <= 1'b0;
            redirect_q    <= '0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else begin
            flush_q <= resolve && mispred;
            if (resolve) begin
                redirect_q <= actual_next;
                if (is_branch && (br_cnt_q != '1))
                    br_cnt_q <= br_cnt_q + 1'b1;
                if (mispred && (mispred_cnt_q != '1))
                    mispred_cnt_q <= mispred_cnt_q + 1'b1;
            end
            if (ent_we) begin
                valid_q[ex_idx] <= ent_valid_d;
                ctr_q[ex_idx]   <= ent_ctr_d;
            end
        end
    end

    // NOTE: tag/target storage is left unreset; valid gates every use of it.
    always_ff @(posedge clk) begin
        if (!rst && data_we) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= actual_next;
        end
    end

    assign bus.flush       = flush_q;
    assign bus.redirect_pc = redirect_q;
    assign bus.br_cnt      = br_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_resolve_bpu.sv
// Directed self-checking bench for branch_resolve_bpu: BTB training, compares,
// JIRL redirect, wrong-path squash, stall, reset and non-branch aliasing cleanup.
module tb_branch_resolve_bpu;
    localparam logic [9:0] BT_NONE = 10'h001;
    localparam logic [9:0] BT_JIRL = 10'h002;
    localparam logic [9:0] BT_B    = 10'h004;
    localparam logic [9:0] BT_BEQ  = 10'h010;
    localparam logic [9:0] BT_BNE  = 10'h020;
    localparam logic [9:0] BT_BLT  = 10'h040;
    localparam logic [9:0] BT_BLTU = 10'h100;

    logic clk = 1'b0;
    logic rst;
    int   tests_run = 0;
    int   tests_failed = 0;

    branch_resolve_bpu_if #(.CNT_W(32)) bus ();

    branch_resolve_bpu #(.ENTRIES(64), .TAG_W(10), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [9:0] bt, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] r1, input logic [31:0] r2,
                         input logic pt, input logic [31:0] ptg);
        bus.ex_valid       = v;
        bus.ex_br_type     = bt;
        bus.ex_pc          = pc;
        bus.ex_imm         = imm;
        bus.ex_rdata1      = r1;
        bus.ex_rdata2      = r2;
        bus.ex_pred_taken  = pt;
        bus.ex_pred_target = ptg;
    endtask

    task automatic lookup(input logic [31:0] pc);
        bus.if_pc = pc;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        lookup(32'h1C00_0000);
        tests_run++; if (bus.if_pred_taken !== 1'b0) begin tests_failed++; $display("FAIL reset_pred_taken: got %0h expected 0", bus.if_pred_taken); end
        tests_run++; if (bus.if_pred_target !== 32'h1C00_0004) begin tests_failed++; $display("FAIL reset_pred_target: got %08h expected 1c000004", bus.if_pred_target); end
        tests_run++; if (bus.flush !== 1'b0) begin tests_failed++; $display("FAIL reset_flush: got %0h expected 0", bus.flush); end
        tests_run++; if (bus.redirect_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_redirect: got %08h expected 0", bus.redirect_pc); end
        tests_run++; if (bus.br_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_br_cnt: got %0d expected 0", bus.br_cnt); end
        tests_run++; if (bus.mispred_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_mispred_cnt: got %0d expected 0", bus.mispred_cnt); end
    endtask

    task automatic test_beq_alloc();
        drive(1'b1, BT_BEQ, 32'h100, 32'h40, 32'd5, 32'd5, 1'b0, 32'h0);
        step();
        bus.ex_valid = 1'b0;
        tests_run++; if (bus.flush !== 1'b1) begin tests_failed++; $display("FAIL beq_alloc_flush: got %0h expected 1", bus.flush); end
        tests_run++; if (bus.redirect_pc !== 32'h140) begin tests_failed++; $display("FAIL beq_alloc_redirect: got %08h expected 00000140", bus.redirect_pc); end
        tests_run++; if (bus.mispred_cnt !== 32'd1) begin tests_failed++; $display("FAIL beq_alloc_mispred_cnt: got %0d expected 1", bus.mispred_cnt); end
        tests_run++; if (bus.br_cnt !== 32'd1) begin tests_failed++; $display("FAIL beq_alloc_br_cnt: got %0d expected 1", bus.br_cnt); end
        lookup(32'h100);
        tests_run++; if (bus.if_pred_taken !== 1'b1) begin tests_failed++; $display("FAIL beq_alloc_pred_taken: got %0h expected 1", bus.if_pred_taken); end
        tests_run++; if (bus.if_pred_target !== 32'h140) begin tests_failed++; $display("FAIL beq_alloc_pred_target: got %08h expected 00000140", bus.if_pred_target); end
        step();
        tests_run++; if (bus.flush !== 1'b0) begin tests_failed++; $display("FAIL beq_alloc_flush_width: got %0h expected 0", bus.flush); end
    endtask

    task automatic test_beq_train();
        drive(1'b1, BT_BEQ, 32'h100, 32'h40, 32'd5, 32'd5, 1'b1, 32'h140);
        step();
        tests_run++; if (bus.flush !== 1'b0) begin tests_failed++; $display("FAIL beq_hit_flush: got %0h expected 0", bus.flush); end
        tests_run++; if (bus.br_cnt !== 32'd2) begin tests_failed++; $display("FAIL beq_hit_br_cnt: got %0d expected 2", bus.br_cnt); end
        tests_run++; if (bus.mispred_cnt !== 32'd1) begin tests_failed++; $display("FAIL beq_hit_mispred_cnt: got %0d expected 1", bus.mispred_cnt); end
        drive(1'b1, BT_BEQ, 32'h100, 32'h40, 32'd1, 32'd2, 1'b1, 32'h140);
        step();
        bus.ex_valid = 1'b0;
        tests_run++; if (bus.flush !== 1'b1) begin tests_failed++; $display("FAIL beq_nt_flush: got %0h expected 1", bus.flush); end
        tests_run++; if (bus.redirect_pc !== 32'h104) begin tests_failed++; $display("FAIL beq_nt_redirect: got %08h expected 00000104", bus.redirect_pc); end
        tests_run++; if (bus.mispred_cnt !== 32'd2) begin tests_failed++; $display("FAIL beq_nt_mispred_cnt: got %0d expected 2", bus.mispred_cnt); end
        lookup(32'h100);
        tests_run++; if (bus.if_pred_taken !== 1'b1) begin tests_failed++; $display("FAIL beq_ctr10_pred_taken: got %0h expected 1", bus.if_pred_taken); end
        tests_run++; if (bus.if_pred_target !== 32'h140) begin tests_failed++; $display("FAIL beq_ctr10_pred_target: got %08h expected 00000140", bus.if_pred_target); end
        step();
    endtask

    task automatic test_signed_unsigned();
        drive(1'b1, BT_BLT, 32'h204, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0);
        step();
        bus.ex_valid = 1'b0;
        tests_run++; if (bus.flush !== 1'b1) begin tests_failed++; $display("FAIL blt_flush: got %0h expected 1", bus.flush); end
        tests_run++; if (bus.redirect_pc !== 32'h224) begin tests_failed++; $display("FAIL blt_redirect: got %08h expected 00000224", bus.redirect_pc); end
        step();
        drive(1'b1, BT_BLTU, 32'h308, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0);
        step();
        bus.ex_valid = 1'b0;
        tests_run++; if (bus.flush !== 1'b0) begin tests_failed++; $display("FAIL bltu_flush: got %0h expected 0", bus.flush); end
        tests_run++; if (bus.redirect_pc !== 32'h30C) begin tests_failed++; $display("FAIL bltu_redirect: got %08h expected 0000030c", bus.redirect_pc); end
        tests_run++; if (bus.br_cnt !== 32'd5) begin tests_failed++; $display("FAIL bltu_br_cnt: got %0d expected 5", bus.br_cnt); end
        tests_run++; if (bus.mispred_cnt !== 32'd3) begin tests_failed++; $display("FAIL bltu_mispred_cnt: got %0d expected 3", bus.mispred_cnt); end
        lookup(32'h308);
        tests_run++; if (bus.if_pred_taken !== 1'b0) begin tests_failed++; $display("FAIL bltu_no_alloc: got %0h expected 0", bus.if_pred_taken); end
        lookup(32'h204);
        tests_run++; if (bus.if_pred_target !== 32'h224) begin tests_failed++; $display("FAIL blt_pred_target: got %08h expected 00000224", bus.if_pred_target); end
    endtask

    task automatic test_jirl_wrong_path();
        drive(1'b1, BT_JIRL, 32'h410, 32'd8, 32'h2000, 32'h0, 1'b1, 32'h3000);
        step();
        tests_run++; if (bus.flush !== 1'b1) begin tests_failed++; $display("FAIL jirl_flush: got %0h expected 1", bus.flush); end
        tests_run++; if (bus.redirect_pc !== 32'h2008) begin tests_failed++; $display("FAIL jirl_redirect: got %08h expected 00002008", bus.redirect_pc); end
        tests_run++; if (bus.br_cnt !== 32'd6) begin tests_failed++; $display("FAIL jirl_br_cnt: got %0d expected 6", bus.br_cnt); end
        tests_run++; if (bus.mispred_cnt !== 32'd4) begin tests_failed++; $display("FAIL jirl_mispred_cnt: got %0d expected 4", bus.mispred_cnt); end
        lookup(32'h410);
        tests_run++; if (bus.if_pred_target !== 32'h2008) begin tests_failed++; $display("FAIL jirl_pred_target: got %08h expected 00002008", bus.if_pred_target); end
        // Valid mispredicting BNE sits in EX during the flush cycle.
        drive(1'b1, BT_BNE, 32'h500, 32'h40, 32'd1, 32'd2, 1'b0, 32'h0);
        step();
        bus.ex_valid = 1'b0;
        tests_run++; if (bus.flush !== 1'b0) begin tests_failed++; $display("FAIL wrongpath_flush: got %0h expected 0", bus.flush); end
        tests_run++; if (bus.br_cnt !== 32'd6) begin tests_failed++; $display("FAIL wrongpath_br_cnt: got %0d expected 6", bus.br_cnt); end
        tests_run++; if (bus.mispred_cnt !== 32'd4) begin tests_failed++; $display("FAIL wrongpath_mispred_cnt: got %0d expected 4", bus.mispred_cnt); end
        tests_run++; if (bus.redirect_pc !== 32'h2008) begin tests_failed++; $display("FAIL wrongpath_redirect_hold: got %08h expected 00002008", bus.redirect_pc); end
        lookup(32'h500);
        tests_run++; if (bus.if_pred_taken !== 1'b0) begin tests_failed++; $display("FAIL wrongpath_no_train: got %0h expected 0", bus.if_pred_taken); end
    endtask

    task automatic test_stall_reset();
        drive(1'b1, BT_BNE, 32'h500, 32'h40, 32'd1, 32'd2, 1'b0, 32'h0);
        bus.ex_stall = 1'b1;
        step();
        tests_run++; if (bus.flush !== 1'b0) begin tests_failed++; $display("FAIL stall_flush: got %0h expected 0", bus.flush); end
        tests_run++; if (bus.br_cnt !== 32'd6) begin tests_failed++; $display("FAIL stall_br_cnt: got %0d expected 6", bus.br_cnt); end
        tests_run++; if (bus.mispred_cnt !== 32'd4) begin tests_failed++; $display("FAIL stall_mispred_cnt: got %0d expected 4", bus.mispred_cnt); end
        bus.ex_stall = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.ex_valid = 1'b0;
        tests_run++; if (bus.flush !== 1'b0) begin tests_failed++; $display("FAIL rst_win_flush: got %0h expected 0", bus.flush); end
        tests_run++; if (bus.redirect_pc !== 32'h0) begin tests_failed++; $display("FAIL rst_win_redirect: got %08h expected 0", bus.redirect_pc); end
        tests_run++; if (bus.br_cnt !== 32'd0) begin tests_failed++; $display("FAIL rst_win_br_cnt: got %0d expected 0", bus.br_cnt); end
        tests_run++; if (bus.mispred_cnt !== 32'd0) begin tests_failed++; $display("FAIL rst_win_mispred_cnt: got %0d expected 0", bus.mispred_cnt); end
        lookup(32'h100);
        tests_run++; if (bus.if_pred_target !== 32'h104) begin tests_failed++; $display("FAIL rst_btb_empty_100: got %08h expected 00000104", bus.if_pred_target); end
        lookup(32'h204);
        tests_run++; if (bus.if_pred_target !== 32'h208) begin tests_failed++; $display("FAIL rst_btb_empty_204: got %08h expected 00000208", bus.if_pred_target); end
        lookup(32'h410);
        tests_run++; if (bus.if_pred_taken !== 1'b0) begin tests_failed++; $display("FAIL rst_btb_empty_410: got %0h expected 0", bus.if_pred_taken); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, BT_B, 32'h600, 32'h100, 32'h0, 32'h0, 1'b0, 32'h0);
        step();
        bus.ex_valid = 1'b0;
        tests_run++; if (bus.redirect_pc !== 32'h700) begin tests_failed++; $display("FAIL b_redirect: got %08h expected 00000700", bus.redirect_pc); end
        lookup(32'h600);
        tests_run++; if (bus.if_pred_taken !== 1'b1) begin tests_failed++; $display("FAIL b_pred_taken: got %0h expected 1", bus.if_pred_taken); end
        step();
        // Non-branch aliasing on the B entry clears it, then an all-zero type predicted taken.
        drive(1'b1, BT_NONE, 32'h600, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        step();
        tests_run++; if (bus.flush !== 1'b0) begin tests_failed++; $display("FAIL nb_hit_flush: got %0h expected 0", bus.flush); end
        tests_run++; if (bus.br_cnt !== 32'd1) begin tests_failed++; $display("FAIL nb_hit_br_cnt: got %0d expected 1", bus.br_cnt); end
        lookup(32'h600);
        tests_run++; if (bus.if_pred_taken !== 1'b0) begin tests_failed++; $display("FAIL nb_hit_invalidate: got %0h expected 0", bus.if_pred_taken); end
        tests_run++; if (bus.if_pred_target !== 32'h604) begin tests_failed++; $display("FAIL nb_hit_target: got %08h expected 00000604", bus.if_pred_target); end
        drive(1'b1, 10'h000, 32'h604, 32'h0, 32'h0, 32'h0, 1'b1, 32'h700);
        step();
        bus.ex_valid = 1'b0;
        tests_run++; if (bus.flush !== 1'b1) begin tests_failed++; $display("FAIL nb_pred_taken_flush: got %0h expected 1", bus.flush); end
        tests_run++; if (bus.redirect_pc !== 32'h608) begin tests_failed++; $display("FAIL nb_pred_taken_redirect: got %08h expected 00000608", bus.redirect_pc); end
        tests_run++; if (bus.br_cnt !== 32'd1) begin tests_failed++; $display("FAIL nb_pred_taken_br_cnt: got %0d expected 1", bus.br_cnt); end
        tests_run++; if (bus.mispred_cnt !== 32'd2) begin tests_failed++; $display("FAIL nb_pred_taken_mispred_cnt: got %0d expected 2", bus.mispred_cnt); end
        step();
        tests_run++; if (bus.flush !== 1'b0) begin tests_failed++; $display("FAIL nb_flush_width: got %0h expected 0", bus.flush); end
    endtask

    initial begin
        rst          = 1'b1;
        bus.if_pc    = 32'h0;
        bus.ex_stall = 1'b0;
        drive(1'b0, 10'h000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        test_reset();
        test_beq_alloc();
        test_beq_train();
        test_signed_unsigned();
        test_jirl_wrong_path();
        test_stall_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
